nios2_oci_dct_capture: RTL
==========================

Name: nios2_oci_dct_capture

Overview:
Parametrised successor to the OCI test-bench monitor. Where the earlier block only received the debug-capture-trace (DCT) word, count and end-of-test flags, this block captures them. Non-empty DCT frames are buffered in a FIFO, drained through a valid/ready read port, and dropped frames are counted. On end of test the block flushes its contents and then signals completion. It sits beside the Nios II OCI and feeds a trace reader or bench scoreboard. It is synthesisable.

Parameters:
DCT_WIDTH, 30, width of dct_buffer.
COUNT_WIDTH, 4, width of dct_count.
DEPTH, 16, FIFO entries; must be a power of 2 and at least 2.
PTR_WIDTH, 4, log2(DEPTH).
OVF_WIDTH, 16, width of the saturating overflow counter.

Ports:
clk  in  1  sole clock; everything is sampled on the rising edge.
reset  in  1  synchronous, active-high reset.
dct_buffer  in  DCT_WIDTH  DCT payload.
dct_count  in  COUNT_WIDTH  number of valid items in dct_buffer; 0 means an empty frame.
dct_valid  in  1  frame strobe; dct_buffer and dct_count are sampled when this is 1.
test_ending  in  1  request to stop capture and begin the drain.
test_has_ended  in  1  test complete; sticky once seen.
rd_ready  in  1  consumer accepts the head entry.
rd_valid  out  1  head entry is available.
rd_data  out  COUNT_WIDTH+DCT_WIDTH  {count, payload} of the head entry.
fill_level  out  PTR_WIDTH+1  number of entries in the FIFO, 0..DEPTH.
overflow_count  out  OVF_WIDTH  dropped non-empty frames; saturates at all-ones.
capture_done  out  1  high once the block has reached the DONE state.

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs):
  - FSM goes to CAPTURE; FIFO pointers clear.
  - fill_level=0, rd_valid=0, overflow_count=0, capture_done=0.
  - The sticky ended flag clears.
  - Reset asserted mid-operation discards all buffered entries at that edge.
- Push request: dct_valid=1 and dct_count!=0 while in CAPTURE. Frames with dct_count=0 are ignored and are not counted as overflow.
- Pop: rd_valid and rd_ready both high. Legal in CAPTURE and in DRAIN.
- Push acceptance: a push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle (simultaneous push and pop at full is accepted).
- Rejected push: overflow_count increments by 1, saturating at 2^OVF_WIDTH-1.
- FIFO read is first-word-fall-through:
  - rd_data = entry at the read pointer, combinational from storage.
  - rd_valid = (fill_level!=0) and state!=DONE.
  - A frame pushed at edge N gives rd_valid=1 after edge N, i.e. one cycle of latency.
- Pointers are PTR_WIDTH bits and wrap modulo DEPTH. fill_level is updated +1, -1 or 0 per cycle, so a simultaneous push and pop leaves it unchanged.
- fill_level=DEPTH means full; fill_level=0 means empty.
- Sticky ended flag: set on any cycle where test_has_ended=1; cleared only by reset.
- FSM states and transitions:
  - CAPTURE: accepts pushes. If test_ending or test_has_ended is high, go to DRAIN at the next edge. A push in that same cycle is still accepted.
  - DRAIN: pushes are ignored and are not counted as overflow; pops continue. Go to DONE when fill_level=0 and the ended flag is set, evaluated after the current cycle's pop. If the FIFO is empty but the ended flag is not yet set, stay in DRAIN.
  - DONE: capture_done=1, rd_valid=0, no pushes, no pops. Stays in DONE until reset.
- If test_ending and test_has_ended both rise in the same CAPTURE cycle with an empty FIFO and no push: CAPTURE -> DRAIN on that edge, then DRAIN -> DONE on the next edge.
- Outputs are held while rd_valid=1 and rd_ready=0.
- rd_data is unspecified (don't-care) while rd_valid=0.

Decomposition:
- Shared package nios2_oci_dct_pkg holds:
  - the state enum {CAPTURE, DRAIN, DONE};
  - default width constants (DCT_WIDTH=30, COUNT_WIDTH=4);
  - a packed struct type for the {count, payload} entry.
- One sub-module: nios2_oci_dct_fifo.
  - Synchronous-reset FWFT FIFO with push, pop, full, empty and level outputs.
  - The top level holds the FSM, push filtering, overflow counter and sticky flag.

Test Plan:
1. Reset, then push 3 frames (count=1/2/3, payload 0x1,0x2,0x3) with rd_ready=0 -> fill_level=3, rd_valid=1, rd_data={1,0x1}. Then rd_ready=1 for 3 cycles -> data returned in order, fill_level=0.
2. Push with count=0, payload 0x3FFFFFFF -> fill_level stays 0 and overflow_count stays 0.
3. Fill to 16 with rd_ready=0, then push 2 more -> fill_level=16, overflow_count=2. Then push and pop together at full -> fill_level stays 16, overflow_count stays 2, and the pushed frame is the last one read out.
4. Wrap-around: 40 push/pop cycles with alternating rd_ready -> all 40 payloads are returned in order with none lost.
5. Load 5 entries, pulse test_ending, and keep pushing -> no further entries are accepted. Drain all 5 with test_has_ended low -> state holds DRAIN and capture_done=0. Pulse test_has_ended -> capture_done=1 on the next edge and rd_valid=0.
6. Assert reset in DRAIN with 4 entries buffered -> fill_level=0, capture_done=0, overflow_count=0. The next push is accepted in CAPTURE.

Source files
------------

// File: rtl/nios2_oci_dct_pkg.sv
// Shared types and default widths for the OCI DCT capture block.
//   dct_state_e  : capture FSM state encoding
//   dct_entry_t  : {count, payload} FIFO entry at the default widths
package nios2_oci_dct_pkg;

  localparam int DEF_DCT_WIDTH   = 30;
  localparam int DEF_COUNT_WIDTH = 4;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } dct_state_e;

  typedef struct packed {
    logic [DEF_COUNT_WIDTH-1:0] count;
    logic [DEF_DCT_WIDTH-1:0]   payload;
  } dct_entry_t;

endpackage

// File: rtl/nios2_oci_dct_fifo.sv
// First-word-fall-through FIFO with synchronous active-high reset.
// Ports:
//   clk, reset       : clock and synchronous reset (clears pointers and level)
//   push_i, wdata_i  : write request and data; dropped when full unless popping
//   pop_i            : read request; ignored when empty
//   rdata_o          : entry at the read pointer (combinational from storage)
//   full_o, empty_o  : level == DEPTH / level == 0
//   level_o          : number of stored entries, 0..DEPTH
module nios2_oci_dct_fifo
  import nios2_oci_dct_pkg::*;
#(
  parameter int WIDTH     = DEF_COUNT_WIDTH + DEF_DCT_WIDTH,
  parameter int DEPTH     = 16,
  parameter int PTR_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [WIDTH-1:0]     wdata_i,
  output logic [WIDTH-1:0]     rdata_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [PTR_WIDTH:0]   level_o
);

  localparam logic [PTR_WIDTH:0] FULL_LVL = (PTR_WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0]   level_q, level_d;
  logic                 do_push, do_pop;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A write at full is legal when the same cycle frees a slot.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (PTR_WIDTH+1)'(1);
      2'b01:   level_d = level_q - (PTR_WIDTH+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: entries are only visible once the level says so.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/nios2_oci_dct_capture.sv
// Captures non-empty DCT frames into a FIFO, drains them through a
// valid/ready port, counts dropped frames and signals completion after
// end of test once the FIFO is empty.
// Ports:
//   clk, reset                 : clock and synchronous active-high reset
//   dct_buffer, dct_count      : frame payload and item count (0 = empty frame)
//   dct_valid                  : frame strobe
//   test_ending                : stop capture, begin drain
//   test_has_ended             : test complete (held in a sticky flag)
//   rd_ready / rd_valid        : read handshake
//   rd_data                    : {count, payload} of the head entry
//   fill_level                 : entries buffered, 0..DEPTH
//   overflow_count             : saturating count of rejected frames
//   capture_done               : DONE state reached
//
// state   | meaning
// CAPTURE | frames pushed, pops allowed
// DRAIN   | pushes ignored, pops continue until empty and test has ended
// DONE    | idle until reset; no pushes, no pops, rd_valid low
module nios2_oci_dct_capture
  import nios2_oci_dct_pkg::*;
#(
  parameter int DCT_WIDTH   = DEF_DCT_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int DEPTH       = 16,
  parameter int PTR_WIDTH   = 4,
  parameter int OVF_WIDTH   = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DCT_WIDTH-1:0]             dct_buffer,
  input  logic [COUNT_WIDTH-1:0]           dct_count,
  input  logic                             dct_valid,
  input  logic                             test_ending,
  input  logic                             test_has_ended,
  input  logic                             rd_ready,
  output logic                             rd_valid,
  output logic [COUNT_WIDTH+DCT_WIDTH-1:0] rd_data,
  output logic [PTR_WIDTH:0]               fill_level,
  output logic [OVF_WIDTH-1:0]             overflow_count,
  output logic                             capture_done
);

  dct_state_e           state_q, state_d;
  logic                 ended_q, ended_d;
  logic [OVF_WIDTH-1:0] ovf_q, ovf_d;
  logic                 push_req, push_acc, pop;
  logic                 fifo_full, fifo_empty;
  logic [PTR_WIDTH:0]   level_after_pop;

  nios2_oci_dct_fifo #(
    .WIDTH     (COUNT_WIDTH + DCT_WIDTH),
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_acc),
    .pop_i   (pop),
    .wdata_i ({dct_count, dct_buffer}),
    .rdata_o (rd_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fill_level)
  );

  assign rd_valid       = !fifo_empty && (state_q != DONE);
  assign pop            = rd_valid && rd_ready;
  assign push_req       = dct_valid && (dct_count != '0) && (state_q == CAPTURE);
  assign push_acc       = push_req && (!fifo_full || pop);
  assign capture_done   = (state_q == DONE);
  assign overflow_count = ovf_q;
  // DRAIN never pushes, so the post-pop level is just level minus the pop.
  assign level_after_pop = fill_level - (PTR_WIDTH+1)'(pop);

  always_comb begin
    ended_d = ended_q || test_has_ended;
    ovf_d   = ovf_q;
    if (push_req && !push_acc && (ovf_q != '1)) ovf_d = ovf_q + OVF_WIDTH'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CAPTURE: if (test_ending || test_has_ended) state_d = DRAIN;
      // Uses this cycle's test_has_ended so a late end-of-test pulse
      // completes on the same edge that latches the flag.
      DRAIN:   if (ended_d && (level_after_pop == '0)) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = CAPTURE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CAPTURE;
      ended_q <= 1'b0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      ended_q <= ended_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
